// File: rtl/muon_trigger_if.sv
// Sample/trigger bundle between the ADC front end and the muon trigger block.
// The master drives the ADC samples. The slave returns the trigger vector and its counter.
interface muon_trigger_if #(
   parameter int ADC_WIDTH = 12
);
   logic [ADC_WIDTH-1:0] ADC0;
   logic [ADC_WIDTH-1:0] ADC1;
   logic [ADC_WIDTH-1:0] ADC2;
   logic [ADC_WIDTH-1:0] ADC_SSD;
   logic [3:0]           MUON_TRIG_OUT;
   logic [15:0]          TRIG_COUNT;

   modport master (
      output ADC0, ADC1, ADC2, ADC_SSD,
      input  MUON_TRIG_OUT, TRIG_COUNT
   );

   modport slave (
      input  ADC0, ADC1, ADC2, ADC_SSD,
      output MUON_TRIG_OUT, TRIG_COUNT
   );
endinterface

// File: rtl/muon_trigger.sv
// Muon trigger generator for the 120 MHz ADC domain. It has four sources: PMT multiplicity, SSD threshold,
// PMT/SSD coincidence and periodic. Each source has edge detection, an enable and a holdoff.
module muon_trigger #(
   parameter int ADC_WIDTH     = 12,
   parameter int HOLDOFF_WIDTH = 8,
   parameter int PERIOD_WIDTH  = 24
) (
   input  logic                     CLK120,
   input  logic                     RESET,
   muon_trigger_if.slave            trig_bus,
   input  logic [ADC_WIDTH-1:0]     PMT_THRES0,
   input  logic [ADC_WIDTH-1:0]     PMT_THRES1,
   input  logic [ADC_WIDTH-1:0]     PMT_THRES2,
   input  logic [ADC_WIDTH-1:0]     SSD_THRES,
   input  logic [2:0]               PMT_MASK,
   input  logic [1:0]               PMT_MULT,
   input  logic [3:0]               COINC_WIN,
   input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF,
   input  logic [PERIOD_WIDTH-1:0]  PERIOD,
   input  logic [3:0]               TRIG_ENABLE
);

   localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE = HOLDOFF_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0]  PER_ONE  = PERIOD_WIDTH'(1);

   // Stage 1: threshold flags
   logic [2:0] over_pmt;
   logic       over_ssd;

   // Stage 2: edge detection, stretching, holdoff, output
   logic                     pmt_prev, ssd_prev, coinc_prev;
   logic [3:0]               pmt_str, ssd_str;
   logic [PERIOD_WIDTH-1:0]  per_cnt;
   logic [HOLDOFF_WIDTH-1:0] hold [4];
   logic [3:0]               trig_out;
   logic [15:0]              trig_count;

   logic [2:0] pmt_masked;
   logic [1:0] pmt_hits;
   logic       pmt_c, pmt_rise, ssd_rise;
   logic       pmt_act, ssd_act, coinc, coinc_rise;
   logic       per_wrap;
   logic [3:0] raw, fire;

   // The stage-1 flags reset high as well, so the first post-reset cycle looks "already above".
   // A sample that is above threshold at release then never counts as a rise.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         over_pmt <= 3'b111;
         over_ssd <= 1'b1;
      end else begin
         over_pmt <= {trig_bus.ADC2 > PMT_THRES2,
                      trig_bus.ADC1 > PMT_THRES1,
                      trig_bus.ADC0 > PMT_THRES0};
         over_ssd <= trig_bus.ADC_SSD > SSD_THRES;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      pmt_masked = over_pmt & PMT_MASK;
      pmt_hits   = 2'(pmt_masked[0]) + 2'(pmt_masked[1]) + 2'(pmt_masked[2]);
      pmt_c      = (PMT_MULT != 2'd0) && (pmt_hits >= PMT_MULT);
      pmt_rise   = pmt_c & ~pmt_prev;
      ssd_rise   = over_ssd & ~ssd_prev;
      pmt_act    = pmt_rise | (pmt_str != 4'd0);
      ssd_act    = ssd_rise | (ssd_str != 4'd0);
      coinc      = pmt_act & ssd_act;
      coinc_rise = coinc & ~coinc_prev;
      per_wrap   = (PERIOD != '0) && (per_cnt >= PERIOD - PER_ONE);
      raw        = {per_wrap, coinc_rise, ssd_rise, pmt_rise};
      fire       = '0;
      for (int i = 0; i < 4; i++) begin
         fire[i] = raw[i] & TRIG_ENABLE[i] & (hold[i] == '0);
      end
   end

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         pmt_prev   <= 1'b1;
         ssd_prev   <= 1'b1;
         coinc_prev <= 1'b1;
         pmt_str    <= 4'd0;
         ssd_str    <= 4'd0;
         per_cnt    <= '0;
         for (int i = 0; i < 4; i++) hold[i] <= '0;
         trig_out   <= 4'd0;
         trig_count <= 16'd0;
      end else begin
         pmt_prev   <= pmt_c;
         ssd_prev   <= over_ssd;
         coinc_prev <= coinc;

         if (pmt_rise)             pmt_str <= COINC_WIN;
         else if (pmt_str != 4'd0) pmt_str <= pmt_str - 4'd1;
         if (ssd_rise)             ssd_str <= COINC_WIN;
         else if (ssd_str != 4'd0) ssd_str <= ssd_str - 4'd1;

         if (PERIOD == '0 || per_wrap) per_cnt <= '0;
         else                          per_cnt <= per_cnt + PER_ONE;

         // Holdoff keeps expiring even after an enable drops mid-window.
         for (int i = 0; i < 4; i++) begin
            if (fire[i])              hold[i] <= HOLDOFF;
            else if (hold[i] != '0)   hold[i] <= hold[i] - HOLD_ONE;
         end

         trig_out <= fire;
         if (trig_out != 4'd0 && trig_count != 16'hFFFF) trig_count <= trig_count + 16'd1;
      end
   end

   assign trig_bus.MUON_TRIG_OUT = trig_out;
   assign trig_bus.TRIG_COUNT    = trig_count;

endmodule

// File: tb/tb_muon_trigger.sv
// Self-checking bench for muon_trigger. A scoreboard queue holds the expected trigger vectors,
// keyed by the cycle on which each one is due.
module tb_muon_trigger;

   localparam int ADC_WIDTH     = 12;
   localparam int HOLDOFF_WIDTH = 8;
   localparam int PERIOD_WIDTH  = 24;

   logic                     CLK120 = 1'b0;
   logic                     RESET;
   logic [ADC_WIDTH-1:0]     PMT_THRES0, PMT_THRES1, PMT_THRES2, SSD_THRES;
   logic [2:0]               PMT_MASK;
   logic [1:0]               PMT_MULT;
   logic [3:0]               COINC_WIN;
   logic [HOLDOFF_WIDTH-1:0] HOLDOFF;
   logic [PERIOD_WIDTH-1:0]  PERIOD;
   logic [3:0]               TRIG_ENABLE;

   muon_trigger_if #(.ADC_WIDTH(ADC_WIDTH)) bus ();

   muon_trigger #(
      .ADC_WIDTH(ADC_WIDTH), .HOLDOFF_WIDTH(HOLDOFF_WIDTH), .PERIOD_WIDTH(PERIOD_WIDTH)
   ) dut (
      .CLK120(CLK120), .RESET(RESET), .trig_bus(bus),
      .PMT_THRES0(PMT_THRES0), .PMT_THRES1(PMT_THRES1), .PMT_THRES2(PMT_THRES2),
      .SSD_THRES(SSD_THRES), .PMT_MASK(PMT_MASK), .PMT_MULT(PMT_MULT),
      .COINC_WIN(COINC_WIN), .HOLDOFF(HOLDOFF), .PERIOD(PERIOD), .TRIG_ENABLE(TRIG_ENABLE)
   );

   always #4 CLK120 = ~CLK120;

   typedef struct {
      int         due;
      logic [3:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   sum_prev = 0;

   task automatic push(input int delay, input logic [3:0] v);
      exp_t e;
      e.due = cyc + delay;
      e.val = v;
      sb_q.push_back(e);
   endtask

   // Advance one edge, then compare the output vector and the counter against the model.
   task automatic tick_check(input string name);
      logic [3:0]  exp_out;
      logic [15:0] exp_cnt;
      logic        rst_edge;
      rst_edge = RESET;
      @(posedge CLK120);
      #1;
      cyc++;
      exp_out = 4'd0;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].due <= cyc) begin
            exp_out |= sb_q[i].val;
            sb_q.delete(i);
         end
      end
      if (rst_edge) begin
         sb_q.delete();
         exp_out  = 4'd0;
         sum_prev = 0;
         exp_cnt  = 16'd0;
      end else begin
         exp_cnt = (sum_prev > 65535) ? 16'hFFFF : 16'(sum_prev);
         if (exp_out != 4'd0) sum_prev++;
      end
      n_checks++;
      if (bus.MUON_TRIG_OUT !== exp_out) begin
         n_fail++;
         $display("FAIL %s trig_out cycle %0d: got %b expected %b", name, cyc, bus.MUON_TRIG_OUT, exp_out);
      end
      n_checks++;
      if (bus.TRIG_COUNT !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s trig_count cycle %0d: got %h expected %h", name, cyc, bus.TRIG_COUNT, exp_cnt);
      end
   endtask

   task automatic run(input int n, input string name);
      for (int i = 0; i < n; i++) tick_check(name);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus.ADC0 = 12'd4000; bus.ADC1 = 12'd0; bus.ADC2 = 12'd0; bus.ADC_SSD = 12'd0;
      PMT_THRES0 = 12'd100; PMT_THRES1 = 12'd100; PMT_THRES2 = 12'd100; SSD_THRES = 12'd100;
      PMT_MASK = 3'b001; PMT_MULT = 2'd1; COINC_WIN = 4'd0; HOLDOFF = '0; PERIOD = '0;
      TRIG_ENABLE = 4'b1111;
      run(3, "reset");
   endtask

   // ADC0 is already above threshold at release, so bit0 must wait for a real rise.
   task automatic test_release_edge();
      RESET = 1'b0;
      run(8, "release_high");
      bus.ADC0 = 12'd50;
      run(4, "drop");
      bus.ADC0 = 12'd4000;
      push(2, 4'b0001);
      run(6, "rise");
      bus.ADC0 = 12'd50;
      run(4, "fall");
   endtask

   task automatic test_multiplicity();
      PMT_MASK = 3'b111; PMT_MULT = 2'd2;
      run(3, "mult_setup");
      bus.ADC0 = 12'd4000; bus.ADC1 = 12'd4000;
      push(2, 4'b0001);
      run(5, "mult_two");
      bus.ADC0 = 12'd0; bus.ADC1 = 12'd0;
      run(4, "mult_drop");
      bus.ADC2 = 12'd4000;
      run(5, "mult_single");
      bus.ADC2 = 12'd0;
      run(4, "mult_drop2");
      PMT_MULT = 2'd0;
      bus.ADC0 = 12'd4000; bus.ADC1 = 12'd4000; bus.ADC2 = 12'd4000;
      run(5, "mult_zero");
      bus.ADC0 = 12'd0; bus.ADC1 = 12'd0; bus.ADC2 = 12'd0;
      run(4, "mult_drop3");
      PMT_MASK = 3'b001; PMT_MULT = 2'd1;
      run(2, "mult_restore");
   endtask

   // The SSD rises 3 or 4 samples after the PMT. Only the first falls inside a 3-cycle window.
   task automatic test_coincidence();
      COINC_WIN = 4'd3;
      run(2, "coinc_setup");
      bus.ADC0 = 12'd4000;
      push(2, 4'b0001);
      run(1, "coinc_a_pmt");
      bus.ADC0 = 12'd0;
      run(2, "coinc_a_gap");
      bus.ADC_SSD = 12'd4000;
      push(2, 4'b0110);
      run(1, "coinc_a_ssd");
      bus.ADC_SSD = 12'd0;
      run(10, "coinc_a_tail");
      bus.ADC0 = 12'd4000;
      push(2, 4'b0001);
      run(1, "coinc_b_pmt");
      bus.ADC0 = 12'd0;
      run(3, "coinc_b_gap");
      bus.ADC_SSD = 12'd4000;
      push(2, 4'b0010);
      run(1, "coinc_b_ssd");
      bus.ADC_SSD = 12'd0;
      run(10, "coinc_b_tail");
      COINC_WIN = 4'd0;
   endtask

   task automatic ssd_edge(input logic expect_pulse, input string name);
      bus.ADC_SSD = 12'd4000;
      if (expect_pulse) push(2, 4'b0010);
      run(1, name);
      bus.ADC_SSD = 12'd0;
      run(3, name);
   endtask

   task automatic test_holdoff();
      HOLDOFF = 8'd10;
      for (int e = 0; e < 9; e++) ssd_edge((e % 3) == 0, "holdoff10");
      run(14, "holdoff_expire");
      TRIG_ENABLE = 4'b1101;
      ssd_edge(1'b0, "disabled");
      TRIG_ENABLE = 4'b1111;
      ssd_edge(1'b1, "reenabled");
      run(14, "holdoff_expire2");
      HOLDOFF = 8'd0;
      for (int e = 0; e < 6; e++) ssd_edge(1'b1, "holdoff0");
      run(4, "holdoff_tail");
   endtask

   task automatic test_periodic();
      PERIOD = 24'd5;
      for (int k = 1; k <= 4; k++) push(5 * k, 4'b1000);
      run(20, "period5");
      PERIOD = 24'd0;
      run(15, "period0");
      PERIOD = 24'd1000;
      run(700, "period1000");
      PERIOD = 24'd5;
      push(1, 4'b1000);
      push(6, 4'b1000);
      push(11, 4'b1000);
      run(12, "period_lowered");
      PERIOD = 24'd0;
      run(3, "period_off");
   endtask

   task automatic test_saturation_and_reset();
      PERIOD = 24'd1;
      for (int i = 0; i < 70000; i++) begin
         push(1, 4'b1000);
         tick_check("saturate");
      end
      n_checks++;
      if (bus.TRIG_COUNT !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL saturate_final: got %h expected ffff", bus.TRIG_COUNT);
      end
      RESET = 1'b1;
      tick_check("reset_midrun");
      n_checks++;
      if (bus.MUON_TRIG_OUT !== 4'd0 || bus.TRIG_COUNT !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_midrun_outputs: got %b/%h expected 0000/0000",
                  bus.MUON_TRIG_OUT, bus.TRIG_COUNT);
      end
      PERIOD = 24'd0;
      RESET  = 1'b0;
      run(5, "after_reset");
   endtask

   initial begin
      test_reset();
      test_release_edge();
      test_multiplicity();
      test_coincidence();
      test_holdoff();
      test_periodic();
      test_saturation_and_reset();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
